// File: rtl/div_frec_pkg.sv
// Shared constants for the programmable Pclk divider.
// Optional rising-edge tick is enabled by defining DIV_FREC_TICK_EN.
package div_frec_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int DIV_RESET_DEF = 4;
  localparam int DIV_MIN       = 2;

endpackage

// File: rtl/div_frec_cnt.sv
// Wrap counter 0..N-1 with high/low phase compare for div_frec.
// The zero flag exists only when DIV_FREC_TICK_EN is defined.
module div_frec_cnt
  import div_frec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Pclk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  output logic             xclk,
  output logic             wrap
`ifdef DIV_FREC_TICK_EN
  ,
  output logic             zero
`endif
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] n_high;

  // Odd N gets the extra cycle in the high phase.
  assign n_high = n - (n >> 1);
  assign wrap   = en && (cnt == n - WIDTH'(1));

`ifdef DIV_FREC_TICK_EN
  assign zero = (cnt == '0);
`endif

  always_ff @(posedge Pclk) begin
    if (reset || !en) begin
      cnt  <= '0;
      xclk <= 1'b0;
    end else begin
      xclk <= (cnt < n_high);
      cnt  <= wrap ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/div_frec.sv
// Programmable clock divider: Xclk period is div_act Pclk cycles.
// Define DIV_FREC_TICK_EN to add the xclk_rise tick output.
module div_frec
  import div_frec_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             Pclk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_ld,
  input  logic [WIDTH-1:0] div_val,
  output logic             Xclk,
  output logic [WIDTH-1:0] div_act
`ifdef DIV_FREC_TICK_EN
  ,
  output logic             xclk_rise
`endif
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(DIV_MIN);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] next_div;
  logic             wrap;

  assign ld_val   = (div_val < MIN_DIV) ? MIN_DIV : div_val;
  assign next_div = div_ld ? ld_val : pending;

  // Divisor only switches at a period boundary or while parked.
  always_ff @(posedge Pclk) begin
    if (reset) begin
      pending <= RST_DIV;
      div_act <= RST_DIV;
    end else begin
      if (div_ld)
        pending <= ld_val;
      if (!en || wrap)
        div_act <= next_div;
    end
  end

`ifdef DIV_FREC_TICK_EN
  logic cnt_zero;

  always_ff @(posedge Pclk) begin
    if (reset)
      xclk_rise <= 1'b0;
    else
      xclk_rise <= en && cnt_zero;
  end
`endif

  div_frec_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .Pclk  (Pclk),
    .reset (reset),
    .en    (en),
    .n     (div_act),
    .xclk  (Xclk),
    .wrap  (wrap)
`ifdef DIV_FREC_TICK_EN
    ,
    .zero  (cnt_zero)
`endif
  );

endmodule

// File: tb/tb_div_frec.sv
// Scenario bench for div_frec with a queue scoreboard of expected outputs.
// Tick checks are compiled in when DIV_FREC_TICK_EN is defined.
module tb_div_frec;
  import div_frec_pkg::*;

  localparam int W = WIDTH_DEF;

  logic         Pclk = 1'b0;
  logic         reset;
  logic         en;
  logic         div_ld;
  logic [W-1:0] div_val;
  logic         Xclk;
  logic [W-1:0] div_act;
`ifdef DIV_FREC_TICK_EN
  logic         xclk_rise;
`endif

  typedef struct {
    logic         x;
    logic [W-1:0] act;
    logic         rise;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 Pclk = ~Pclk;

  div_frec dut (
    .Pclk      (Pclk),
    .reset     (reset),
    .en        (en),
    .div_ld    (div_ld),
    .div_val   (div_val),
    .Xclk      (Xclk),
    .div_act   (div_act)
`ifdef DIV_FREC_TICK_EN
    ,
    .xclk_rise (xclk_rise)
`endif
  );

  task automatic tick;
    @(posedge Pclk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e_n, input logic l,
                       input int v, input logic x, input int a,
                       input logic rs);
    exp_t t;
    reset   = r;
    en      = e_n;
    div_ld  = l;
    div_val = W'(v);
    t.x     = x;
    t.act   = W'(a);
    t.rise  = rs;
    exp_q.push_back(t);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 4, 0);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (Xclk !== e.x || div_act !== e.act) begin
        n_err++;
        $display("FAIL reset[%0d] Xclk=%b div_act=%0d want %b %0d",
                 i, Xclk, div_act, e.x, e.act);
      end
    end
  endtask

  task automatic test_default;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, (i % 4) < 2, 4, (i % 4) == 0);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (Xclk !== e.x || div_act !== e.act) begin
        n_err++;
        $display("FAIL default[%0d] Xclk=%b div_act=%0d want %b %0d",
                 i, Xclk, div_act, e.x, e.act);
      end
    end
  endtask

  task automatic test_load5;
    logic [0:13] xs = 14'b11001110011100;
    int acts [14] = '{4, 4, 4, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    for (int i = 0; i < 14; i++) begin
      drive(0, 1, i == 0, 5, xs[i], acts[i], 0);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (Xclk !== e.x || div_act !== e.act) begin
        n_err++;
        $display("FAIL load5[%0d] Xclk=%b div_act=%0d want %b %0d",
                 i, Xclk, div_act, e.x, e.act);
      end
    end
  endtask

  task automatic test_clamp;
    logic [0:8] xs = 9'b111001010;
    int acts [9] = '{5, 5, 5, 5, 2, 2, 2, 2, 2};
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, i < 2, i, xs[i], acts[i], 0);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (Xclk !== e.x || div_act !== e.act) begin
        n_err++;
        $display("FAIL clamp[%0d] Xclk=%b div_act=%0d want %b %0d",
                 i, Xclk, div_act, e.x, e.act);
      end
    end
  endtask

  task automatic test_en_drop;
    logic [0:11] ens = 12'b111100111111;
    logic [0:11] lds = 12'b100100000000;
    logic [0:11] xs  = 12'b101100110110;
    int vals [12] = '{6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    int acts [12] = '{2, 6, 6, 6, 3, 3, 3, 3, 3, 3, 3, 3};
    for (int i = 0; i < 12; i++) begin
      drive(0, ens[i], lds[i], vals[i], xs[i], acts[i], 0);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (Xclk !== e.x || div_act !== e.act) begin
        n_err++;
        $display("FAIL en_drop[%0d] Xclk=%b div_act=%0d want %b %0d",
                 i, Xclk, div_act, e.x, e.act);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [0:14] rst = 15'b000001100000000;
    logic [0:14] lds = 15'b100001100000000;
    logic [0:14] xs  = 15'b110110011001100;
    int vals [15] = '{9, 0, 0, 0, 0, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    int acts [15] = '{3, 3, 9, 9, 9, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    for (int i = 0; i < 15; i++) begin
      drive(rst[i], 1, lds[i], vals[i], xs[i], acts[i], 0);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (Xclk !== e.x || div_act !== e.act) begin
        n_err++;
        $display("FAIL reset_mid[%0d] Xclk=%b div_act=%0d want %b %0d",
                 i, Xclk, div_act, e.x, e.act);
      end
    end
  endtask

  task automatic test_tick;
    logic [0:12] xs = 13'b1100110110110;
    logic [0:12] rs = 13'b1000100100100;
    int acts [13] = '{4, 4, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    for (int i = 0; i < 13; i++) begin
      drive(0, 1, i == 0, 3, xs[i], acts[i], rs[i]);
      tick();
      e = exp_q.pop_front();
      n_chk++;
      if (Xclk !== e.x || div_act !== e.act) begin
        n_err++;
        $display("FAIL tick[%0d] Xclk=%b div_act=%0d want %b %0d",
                 i, Xclk, div_act, e.x, e.act);
      end
`ifdef DIV_FREC_TICK_EN
      n_chk++;
      if (xclk_rise !== e.rise) begin
        n_err++;
        $display("FAIL tick_rise[%0d] xclk_rise=%b want %b",
                 i, xclk_rise, e.rise);
      end
`endif
    end
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b0;
    div_ld  = 1'b0;
    div_val = '0;
    test_reset();
    test_default();
    test_load5();
    test_clamp();
    test_en_drop();
    test_reset_mid();
    test_tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_frec.md
DIV_FREC -- requirements
Module: div_frec

Interface
REQ-001 Parameter WIDTH, default 16: width of divisor ports and registers.
REQ-002 Parameter DIV_RESET, default 4: divisor in effect after reset.
REQ-003 Pclk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  high = Xclk toggles; low = Xclk parked low.
REQ-006 div_ld  input  1  one-cycle strobe; captures div_val as the pending divisor.
REQ-007 div_val  input  WIDTH  requested divisor N, in Pclk cycles per Xclk period.
REQ-008 Xclk  output  1  divided clock, registered, glitch-free.
REQ-009 div_act  output  WIDTH  divisor currently in effect.
REQ-010 xclk_rise  output  1  one-cycle tick; present only under DIV_FREC_TICK_EN.

Function
REQ-011 Internal counter cnt SHALL count 0..N-1 and wrap to 0, where N = div_act.
REQ-012 Phase split: H = N - floor(N/2) high cycles, L = floor(N/2) low cycles (50% duty for even N; odd N has one extra high cycle).
REQ-013 On each edge with en=1: Xclk <= (cnt < H); cnt <= (cnt==N-1) ? 0 : cnt+1.
REQ-014 Latency: Xclk rises on the first enabled edge after cnt=0; period is exactly N Pclk cycles.
REQ-015 On each edge with en=0: cnt <= 0 and Xclk <= 0; a high phase may be truncated.
REQ-016 div_ld=1 SHALL load pending <= max(div_val, 2); values 0 and 1 clamp to 2; with multiple loads before a wrap, the last one wins.
REQ-017 div_act <= pending only on the wrap edge (cnt==N-1 with en=1) or on any edge with en=0, so no partial period occurs.
REQ-018 If div_ld coincides with an update edge (REQ-017), the newly loaded clamped value SHALL become div_act on that same edge (bypass).
REQ-019 Divisor arithmetic SHALL be unsigned WIDTH-bit, with no overflow for N up to 2^WIDTH-1.

Reset
REQ-020 reset=1 SHALL force cnt=0, Xclk=0, xclk_rise=0, pending=DIV_RESET, div_act=DIV_RESET; it has priority over en and div_ld.
REQ-021 Reset asserted mid-period SHALL take effect on the next edge; after release with en=1, Xclk rises on the first edge.

Configuration
REQ-022 With DIV_FREC_TICK_EN defined: port xclk_rise SHALL exist and xclk_rise <= (en && cnt==0), high exactly on the edges where Xclk rises.
REQ-023 Without DIV_FREC_TICK_EN: port xclk_rise and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-024 Shared package div_frec_pkg SHALL hold the defaults for WIDTH and DIV_RESET and the constant DIV_MIN=2.
REQ-025 One sub-module, div_frec_cnt (wrap counter plus high/low compare), is natural.
REQ-026 Divisor clamp and the pending/active logic SHALL live in the top level.

Verification
REQ-027 Reset, then en=1 with default N=4 -> Xclk pattern 1,1,0,0 repeating; div_act=4.
REQ-028 div_ld with div_val=5 mid-period -> the current 4-cycle period completes, then Xclk pattern 1,1,1,0,0; div_act changes to 5 only at the wrap.
REQ-029 div_ld with div_val=0, then div_val=1 -> div_act=2; Xclk toggles every cycle.
REQ-030 en dropped during a high phase with N=6 -> Xclk=0 on the next edge; on re-enable, Xclk rises on the first edge and div_act is updated to pending.
REQ-031 reset asserted while Xclk is high with div_act=9 -> next edge Xclk=0 and div_act=4; loads issued during reset are ignored.
REQ-032 With DIV_FREC_TICK_EN and N=3 -> xclk_rise pulses for 1 cycle every 3 cycles, aligned with each Xclk rising edge.
